// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared defaults and entry type for the IF->ID pipeline register
package if_id_pkg;

  localparam int unsigned IF_ID_INSTR_W   = 32;
  localparam int unsigned IF_ID_PC_W      = 32;
  localparam logic [31:0] IF_ID_NOP_INSTR = 32'h0000_0000;

  // One fetched instruction travelling from fetch to decode.
  typedef struct packed {
    logic [IF_ID_INSTR_W-1:0] instr;
    logic [IF_ID_PC_W-1:0]    pc4;
  } if_id_entry_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF->ID pipeline register with handshake, optional skid entry, flush and stall counter
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int unsigned        INSTR_W   = IF_ID_INSTR_W,
  parameter int unsigned        PC_W      = IF_ID_PC_W,
  parameter bit                 SKID      = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR),
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Same layout as if_id_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry_q;
  entry_t out_entry_d;
  entry_t skid_entry;
  logic   out_valid_q;
  logic   out_valid_d;
  logic   skid_valid;
  logic   in_xfer;
  logic   out_load;
  logic   skid_load;

  assign in_entry  = '{instr: in_instr, pc4: in_pc4};
  assign in_xfer   = in_valid && in_ready;
  // Output register may take new data when it is empty or being consumed.
  assign out_load  = !out_valid_q || out_ready;
  // Only reachable with a skid entry: input accepted while output is stalled.
  assign skid_load = !out_load && in_xfer;

  generate
    if (SKID) begin : g_skid
      entry_t skid_entry_q;
      entry_t skid_entry_d;
      logic   skid_valid_q;
      logic   skid_valid_d;

      // Skid captures the input behind a stalled output; drains when output frees up.
      always_comb begin
        skid_valid_d = skid_valid_q;
        skid_entry_d = skid_entry_q;
        if (flush) begin
          skid_valid_d = 1'b0;
        end else if (skid_load) begin
          skid_valid_d = 1'b1;
          skid_entry_d = in_entry;
        end else if (out_load) begin
          skid_valid_d = 1'b0;
        end
      end

      // Skid register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          skid_valid_q <= 1'b0;
          skid_entry_q <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_entry_q <= skid_entry_d;
        end
      end

      assign skid_valid = skid_valid_q;
      assign skid_entry = skid_entry_q;
      // Registered ready: fetch is never combinationally coupled to decode.
      assign in_ready   = !skid_valid_q;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_entry = '0;
      assign in_ready   = !out_valid_q || out_ready;
    end
  endgenerate

  // Output register: flush empties it, otherwise refill from skid first, then input.
  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_entry_d = skid_entry;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_entry_d = in_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_entry_q <= '{instr: NOP_INSTR, pc4: '0};
    end else begin
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_valid_q ? out_entry_q.instr : NOP_INSTR;
  assign out_pc4   = out_entry_q.pc4;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid_q && !out_ready),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        out_ready;

  logic        d_in_ready, d_out_valid;
  logic [31:0] d_out_instr, d_out_pc4;
  logic [15:0] d_stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_instr, s_out_pc4;
  logic [3:0]  s_stall_cnt;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_instr, n_out_pc4;
  logic [15:0] n_stall_cnt;

  int checks;
  int errors;

  localparam logic [31:0] I_A = 32'h0010_0093;
  localparam logic [31:0] I_B = 32'h0020_0113;
  localparam logic [31:0] I_C = 32'h0030_0193;
  localparam logic [31:0] I_D = 32'h0040_0213;
  localparam logic [31:0] I_E = 32'h0050_0293;

  if_id_stage #(.SKID(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_instr(d_out_instr),
    .out_pc4(d_out_pc4), .stall_cnt(d_stall_cnt)
  );

  if_id_stage #(.SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_pc4(s_out_pc4), .stall_cnt(s_stall_cnt)
  );

  if_id_stage #(.SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
    .out_pc4(n_out_pc4), .stall_cnt(n_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    in_valid = v;
    in_instr = instr;
    in_pc4   = pc4;
  endtask

  initial begin
    logic [31:0] stream_i [4];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, I_E, 32'd99);

    // Reset with input presented: nothing may be captured.
    tick();
    tick();
    check_eq("rst_out_valid", {63'd0, d_out_valid}, 64'd0);
    check_eq("rst_out_instr", {32'd0, d_out_instr}, 64'd0);
    check_eq("rst_out_pc4", {32'd0, d_out_pc4}, 64'd0);
    check_eq("rst_stall_cnt", {48'd0, d_stall_cnt}, 64'd0);
    drive(1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", {63'd0, d_in_ready}, 64'd1);
    check_eq("rst_idle_valid", {63'd0, d_out_valid}, 64'd0);

    // Stream A..D at full throughput.
    stream_i[0] = I_A; stream_i[1] = I_B; stream_i[2] = I_C; stream_i[3] = I_D;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_i[i], 32'(4 * (i + 1)));
      tick();
      check_eq($sformatf("stream_valid_%0d", i), {63'd0, d_out_valid}, 64'd1);
      check_eq($sformatf("stream_instr_%0d", i), {32'd0, d_out_instr}, {32'd0, stream_i[i]});
      check_eq($sformatf("stream_pc4_%0d", i), {32'd0, d_out_pc4}, 64'(4 * (i + 1)));
    end
    drive(1'b0, 32'd0, 32'd0);
    tick();
    check_eq("stream_drain_valid", {63'd0, d_out_valid}, 64'd0);
    check_eq("stream_drain_nop", {32'd0, d_out_instr}, 64'd0);
    check_eq("stream_pc4_held", {32'd0, d_out_pc4}, 64'd16);

    // Backpressure: A to output, B into skid, C waits.
    drive(1'b1, I_A, 32'd4);
    tick();
    out_ready = 1'b0;
    drive(1'b1, I_B, 32'd8);
    check_eq("bp_ready_before_skid", {63'd0, d_in_ready}, 64'd1);
    tick();
    drive(1'b1, I_C, 32'd12);
    check_eq("bp_ready_skid_full", {63'd0, d_in_ready}, 64'd0);
    tick();
    tick();
    check_eq("bp_stall_cnt", {48'd0, d_stall_cnt}, 64'd3);
    check_eq("bp_out_stable", {32'd0, d_out_instr}, {32'd0, I_A});
    out_ready = 1'b1;
    tick();
    check_eq("bp_out_b", {32'd0, d_out_instr}, {32'd0, I_B});
    check_eq("bp_out_b_pc4", {32'd0, d_out_pc4}, 64'd8);
    check_eq("bp_ready_after_drain", {63'd0, d_in_ready}, 64'd1);
    tick();
    check_eq("bp_out_c", {32'd0, d_out_instr}, {32'd0, I_C});
    check_eq("bp_out_c_pc4", {32'd0, d_out_pc4}, 64'd12);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    check_eq("bp_empty", {63'd0, d_out_valid}, 64'd0);
    check_eq("bp_stall_hold", {48'd0, d_stall_cnt}, 64'd3);

    // Flush with A in output, B in skid, C presented.
    out_ready = 1'b0;
    drive(1'b1, I_A, 32'd4);
    tick();
    drive(1'b1, I_B, 32'd8);
    tick();
    drive(1'b1, I_C, 32'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    check_eq("flush_valid", {63'd0, d_out_valid}, 64'd0);
    check_eq("flush_nop", {32'd0, d_out_instr}, 64'd0);
    check_eq("flush_in_ready", {63'd0, d_in_ready}, 64'd1);
    check_eq("flush_stall_kept", {48'd0, d_stall_cnt}, 64'd5);
    out_ready = 1'b1;
    tick();
    check_eq("flush_no_b", {63'd0, d_out_valid}, 64'd0);
    tick();
    check_eq("flush_no_c", {63'd0, d_out_valid}, 64'd0);

    // Flush discards a same-cycle input transfer into an empty stage.
    drive(1'b1, I_D, 32'd16);
    flush = 1'b1;
    check_eq("flush_in_accepted", {63'd0, d_in_ready}, 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    check_eq("flush_in_dropped", {63'd0, d_out_valid}, 64'd0);

    // Saturation: fresh reset, hold one instruction stalled for 20 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, I_A, 32'd4);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check_eq("sat_start", {60'd0, s_stall_cnt}, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    check_eq("sat_reach", {60'd0, s_stall_cnt}, 64'd15);
    for (int i = 0; i < 5; i++) tick();
    check_eq("sat_hold", {60'd0, s_stall_cnt}, 64'd15);
    check_eq("wide_cnt_20", {48'd0, d_stall_cnt}, 64'd20);
    check_eq("sat_out_stable", {32'd0, s_out_instr}, {32'd0, I_A});

    // No-skid variant: ready is combinational on out_ready.
    check_eq("noskid_ready_stalled", {63'd0, n_in_ready}, 64'd0);
    check_eq("noskid_out_a", {32'd0, n_out_instr}, {32'd0, I_A});
    out_ready = 1'b1;
    drive(1'b1, I_E, 32'd20);
    #1;
    check_eq("noskid_ready_same_cycle", {63'd0, n_in_ready}, 64'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check_eq("noskid_out_e", {32'd0, n_out_instr}, {32'd0, I_E});
    check_eq("noskid_out_e_pc4", {32'd0, n_out_pc4}, 64'd20);
    check_eq("noskid_out_valid", {63'd0, n_out_valid}, 64'd1);
    tick();
    check_eq("noskid_drained", {63'd0, n_out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
